// File: rtl/bus_arbiter.sv
// Two-requester (CPU/DMA) round-robin memory bus arbiter.
// Each access is held on the bus for WAIT_CYCLES cycles, then acknowledged for one cycle.
module bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic [15:0] dma_address,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_we,
    output logic [7:0]  dma_rdata,
    output logic        dma_ack,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_bus_enable,
    output logic        mem_write_enable,
    input  logic [7:0]  mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    localparam logic [2:0] CNT_LOAD = 3'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;     // 1 = DMA owns the current access
    logic        last_q, last_d;       // 1 = DMA was granted last
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic [7:0]  dma_rdata_q, dma_rdata_d;
    logic        grant_dma;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // On a tie the requester that was not granted last wins.
    assign grant_dma = dma_req && (!cpu_req || !last_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    owner_d = grant_dma;
                    last_d  = grant_dma;
                    addr_d  = grant_dma ? dma_address : cpu_address;
                    wdata_d = grant_dma ? dma_wdata   : cpu_wdata;
                    we_d    = grant_dma ? dma_we      : cpu_we;
                    cnt_d   = CNT_LOAD;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 3'd0) begin
                    state_d = ACK;
                    if (!we_q) begin
                        if (owner_q) dma_rdata_d = mem_rdata;
                        else         cpu_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_bus_enable   = (state_q == ACCESS);
    assign mem_write_enable = mem_bus_enable && we_q;
    assign mem_address      = mem_bus_enable ? addr_q  : '0;
    assign mem_wdata        = mem_bus_enable ? wdata_q : '0;
    assign cpu_ack          = (state_q == ACK) && !owner_q;
    assign dma_ack          = (state_q == ACK) &&  owner_q;
    assign cpu_rdata        = cpu_rdata_q;
    assign dma_rdata        = dma_rdata_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (WAIT_CYCLES 1 and 3) checked every cycle
// against a transaction-age model, plus directed scenarios with literal expectations.
module tb_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n            [2];
    logic        cpu_req          [2];
    logic [15:0] cpu_address      [2];
    logic [7:0]  cpu_wdata        [2];
    logic        cpu_we           [2];
    logic [7:0]  cpu_rdata        [2];
    logic        cpu_ack          [2];
    logic        dma_req          [2];
    logic [15:0] dma_address      [2];
    logic [7:0]  dma_wdata        [2];
    logic        dma_we           [2];
    logic [7:0]  dma_rdata        [2];
    logic        dma_ack          [2];
    logic [15:0] mem_address      [2];
    logic [7:0]  mem_wdata        [2];
    logic        mem_bus_enable   [2];
    logic        mem_write_enable [2];
    logic [7:0]  mem_rdata        [2];
    logic        busy             [2];

    bus_arbiter #(.WAIT_CYCLES(1)) u_dut0 (
        .clk(clk), .reset(rst_n[0]),
        .cpu_req(cpu_req[0]), .cpu_address(cpu_address[0]), .cpu_wdata(cpu_wdata[0]),
        .cpu_we(cpu_we[0]), .cpu_rdata(cpu_rdata[0]), .cpu_ack(cpu_ack[0]),
        .dma_req(dma_req[0]), .dma_address(dma_address[0]), .dma_wdata(dma_wdata[0]),
        .dma_we(dma_we[0]), .dma_rdata(dma_rdata[0]), .dma_ack(dma_ack[0]),
        .mem_address(mem_address[0]), .mem_wdata(mem_wdata[0]),
        .mem_bus_enable(mem_bus_enable[0]), .mem_write_enable(mem_write_enable[0]),
        .mem_rdata(mem_rdata[0]), .busy(busy[0])
    );

    bus_arbiter #(.WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .reset(rst_n[1]),
        .cpu_req(cpu_req[1]), .cpu_address(cpu_address[1]), .cpu_wdata(cpu_wdata[1]),
        .cpu_we(cpu_we[1]), .cpu_rdata(cpu_rdata[1]), .cpu_ack(cpu_ack[1]),
        .dma_req(dma_req[1]), .dma_address(dma_address[1]), .dma_wdata(dma_wdata[1]),
        .dma_we(dma_we[1]), .dma_rdata(dma_rdata[1]), .dma_ack(dma_ack[1]),
        .mem_address(mem_address[1]), .mem_wdata(mem_wdata[1]),
        .mem_bus_enable(mem_bus_enable[1]), .mem_write_enable(mem_write_enable[1]),
        .mem_rdata(mem_rdata[1]), .busy(busy[1])
    );

    int vectors     = 0;
    int miscompares = 0;
    bit done        = 1'b0;

    function automatic int wc(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: age counts cycles since grant (0 = idle, 1..W = bus cycles, W+1 = ack cycle).
    int          age     [2] = '{0, 0};
    bit          m_owner [2] = '{0, 0};
    bit          m_last  [2] = '{1, 1};
    logic [15:0] m_addr  [2] = '{16'h0, 16'h0};
    logic [7:0]  m_wdata [2] = '{8'h0, 8'h0};
    bit          m_we    [2] = '{0, 0};
    logic [7:0]  m_crd   [2] = '{8'h0, 8'h0};
    logic [7:0]  m_drd   [2] = '{8'h0, 8'h0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k]) begin
                age[k] = 0; m_last[k] = 1'b1; m_crd[k] = 8'h00; m_drd[k] = 8'h00;
            end else if (age[k] == 0) begin
                if (cpu_req[k] || dma_req[k]) begin
                    m_owner[k] = cpu_req[k] ? (dma_req[k] && !m_last[k]) : 1'b1;
                    m_last[k]  = m_owner[k];
                    m_addr[k]  = m_owner[k] ? dma_address[k] : cpu_address[k];
                    m_wdata[k] = m_owner[k] ? dma_wdata[k]   : cpu_wdata[k];
                    m_we[k]    = m_owner[k] ? dma_we[k]      : cpu_we[k];
                    age[k]     = 1;
                end
            end else if (age[k] <= wc(k)) begin
                if (age[k] == wc(k) && !m_we[k]) begin
                    if (m_owner[k]) m_drd[k] = mem_rdata[k];
                    else            m_crd[k] = mem_rdata[k];
                end
                age[k]++;
            end else begin
                age[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            for (int k = 0; k < 2; k++) begin
                logic acc, ak;
                logic [44:0] e, a;
                acc = (age[k] >= 1) && (age[k] <= wc(k));
                ak  = (age[k] == wc(k) + 1);
                e = {acc, acc & m_we[k], acc ? m_addr[k] : 16'h0, acc ? m_wdata[k] : 8'h0,
                     ak & !m_owner[k], ak & m_owner[k], m_crd[k], m_drd[k], (age[k] != 0)};
                a = {mem_bus_enable[k], mem_write_enable[k], mem_address[k], mem_wdata[k],
                     cpu_ack[k], dma_ack[k], cpu_rdata[k], dma_rdata[k], busy[k]};
                chk($sformatf("model_dut%0d {en,we,addr,wdata,cack,dack,crd,drd,busy}", k), a, e);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    initial begin
        int order[$];
        int acks;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; cpu_req[k] = 1'b0; dma_req[k] = 1'b0;
            cpu_address[k] = '0; cpu_wdata[k] = '0; cpu_we[k] = 1'b0;
            dma_address[k] = '0; dma_wdata[k] = '0; dma_we[k] = 1'b0;
            mem_rdata[k] = '0;
        end
        step(1);
        chk("rst busy", busy[0], 0);
        chk("rst mem_en", mem_bus_enable[0], 0);
        chk("rst cpu_rdata", cpu_rdata[1], 0);
        chk("rst acks", {cpu_ack[0], dma_ack[0]}, 0);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        // Single CPU read, WAIT_CYCLES=1
        cpu_address[0] = 16'h4005; cpu_we[0] = 1'b0; mem_rdata[0] = 8'hA5; cpu_req[0] = 1'b1;
        step(1);
        chk("rd1 mem_en", mem_bus_enable[0], 1);
        chk("rd1 mem_addr", mem_address[0], 16'h4005);
        step(1);
        chk("rd1 cpu_ack", cpu_ack[0], 1);
        chk("rd1 cpu_rdata", cpu_rdata[0], 8'hA5);
        chk("rd1 mem_en off", mem_bus_enable[0], 0);
        cpu_req[0] = 1'b0;
        step(1);
        chk("rd1 ack gone", cpu_ack[0], 0);

        // Simultaneous requests straight after reset: CPU first
        rst_n[0] = 1'b0; step(1); rst_n[0] = 1'b1;
        cpu_address[0] = 16'hC010; cpu_wdata[0] = 8'h3C; cpu_we[0] = 1'b1; cpu_req[0] = 1'b1;
        dma_address[0] = 16'h0020; dma_we[0] = 1'b0; dma_req[0] = 1'b1; mem_rdata[0] = 8'h5A;
        step(1);
        chk("tie cpu we", mem_write_enable[0], 1);
        chk("tie cpu addr", mem_address[0], 16'hC010);
        chk("tie cpu wdata", mem_wdata[0], 8'h3C);
        step(1);
        chk("tie acks", {cpu_ack[0], dma_ack[0]}, 2'b10);
        cpu_req[0] = 1'b0;
        step(2);
        chk("tie dma addr", mem_address[0], 16'h0020);
        step(1);
        chk("tie dma_ack", dma_ack[0], 1);
        chk("tie dma_rdata", dma_rdata[0], 8'h5A);
        chk("tie cpu_rdata held", cpu_rdata[0], 8'h00);
        dma_req[0] = 1'b0;
        step(1);

        // Both held for six transactions: strict alternation
        cpu_we[0] = 1'b0; cpu_req[0] = 1'b1; dma_req[0] = 1'b1;
        repeat (18) begin
            step(1);
            if (cpu_ack[0]) order.push_back(0);
            if (dma_ack[0]) order.push_back(1);
        end
        cpu_req[0] = 1'b0; dma_req[0] = 1'b0;
        chk("rr count", order.size(), 6);
        foreach (order[i]) chk($sformatf("rr grant%0d", i), order[i], i % 2);
        step(2);

        // DMA read with WAIT_CYCLES=3: sampled on third bus cycle only
        dma_address[1] = 16'h1234; dma_we[1] = 1'b0; mem_rdata[1] = 8'hEE; dma_req[1] = 1'b1;
        step(1);
        chk("w3 en c1", mem_bus_enable[1], 1);
        mem_rdata[1] = 8'h11; step(1);
        mem_rdata[1] = 8'h22; step(1);
        chk("w3 en c3", mem_bus_enable[1], 1);
        mem_rdata[1] = 8'h33; step(1);
        chk("w3 dma_ack", dma_ack[1], 1);
        chk("w3 dma_rdata", dma_rdata[1], 8'h33);
        chk("w3 en off", mem_bus_enable[1], 0);
        dma_req[1] = 1'b0; mem_rdata[1] = 8'h44;
        step(1);
        chk("w3 rdata held", dma_rdata[1], 8'h33);

        // Reset during the second bus cycle of a CPU read
        cpu_address[1] = 16'h8000; cpu_we[1] = 1'b0; mem_rdata[1] = 8'h77; cpu_req[1] = 1'b1;
        step(2);
        dma_address[1] = 16'h00D0; dma_we[1] = 1'b0; dma_req[1] = 1'b1;
        rst_n[1] = 1'b0;
        #1;
        chk("rstmid mem_en", mem_bus_enable[1], 0);
        chk("rstmid busy", busy[1], 0);
        chk("rstmid cpu_ack", cpu_ack[1], 0);
        cpu_req[1] = 1'b0;
        step(1);
        chk("rstmid cpu_rdata", cpu_rdata[1], 8'h00);
        rst_n[1] = 1'b1;
        step(1);
        chk("rstmid dma granted", mem_address[1], 16'h00D0);
        step(3);
        chk("rstmid dma_ack", dma_ack[1], 1);
        chk("rstmid dma_rdata", dma_rdata[1], 8'h77);
        dma_req[1] = 1'b0;
        step(1);

        // CPU drops req after first bus cycle
        cpu_address[1] = 16'h5555; cpu_we[1] = 1'b0; mem_rdata[1] = 8'h9C; cpu_req[1] = 1'b1;
        step(1);
        cpu_req[1] = 1'b0;
        acks = 0;
        repeat (5) begin
            step(1);
            acks += int'(cpu_ack[1]);
        end
        chk("drop ack count", acks, 1);
        chk("drop idle", busy[1], 0);
        chk("drop rdata", cpu_rdata[1], 8'h9C);

        // Randomized traffic on both instances
        repeat (700) begin
            for (int k = 0; k < 2; k++) begin
                mem_rdata[k] = 8'($urandom);
                if (!rst_n[k]) rst_n[k] = 1'b1;
                else if ($urandom_range(0, 249) == 0) rst_n[k] = 1'b0;
                if (!cpu_req[k]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        cpu_req[k] = 1'b1; cpu_address[k] = 16'($urandom);
                        cpu_wdata[k] = 8'($urandom); cpu_we[k] = 1'($urandom_range(0, 1));
                    end
                end else if (cpu_ack[k]) begin
                    if ($urandom_range(0, 3) != 0) cpu_req[k] = 1'b0;
                end else if ($urandom_range(0, 49) == 0) cpu_req[k] = 1'b0;
                if (!dma_req[k]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        dma_req[k] = 1'b1; dma_address[k] = 16'($urandom);
                        dma_wdata[k] = 8'($urandom); dma_we[k] = 1'($urandom_range(0, 1));
                    end
                end else if (dma_ack[k]) begin
                    if ($urandom_range(0, 3) != 0) dma_req[k] = 1'b0;
                end else if ($urandom_range(0, 49) == 0) dma_req[k] = 1'b0;
            end
            step(1);
        end

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The module SHALL have parameter WAIT_CYCLES, default 1, giving the memory cycles the address is held before read data is sampled (legal 1..7).
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-005 cpu_address  input  16  CPU access address.
REQ-006 cpu_wdata  input  8  CPU write data.
REQ-007 cpu_we  input  1  CPU access is a write.
REQ-008 cpu_rdata  output  8  CPU read data, registered.
REQ-009 cpu_ack  output  1  one-cycle CPU completion pulse.
REQ-010 dma_req, dma_address[15:0], dma_wdata[7:0], dma_we, dma_rdata[7:0], dma_ack SHALL mirror REQ-004..009 for the DMA requester.
REQ-011 mem_address  output  16  address to memory bus.
REQ-012 mem_wdata  output  8  write data to memory bus.
REQ-013 mem_bus_enable  output  1  memory access active.
REQ-014 mem_write_enable  output  1  memory access is a write.
REQ-015 mem_rdata  input  8  read data from memory bus.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, ACK; transitions IDLE->ACCESS on any request, ACCESS->ACK when wait counter reaches zero, ACK->IDLE unconditionally.
REQ-018 In IDLE with exactly one request asserted, that requester SHALL be granted.
REQ-019 In IDLE with both requests asserted, the requester not granted last SHALL win (round-robin); last_grant updates on every grant.
REQ-020 On grant, address, wdata, we and grant owner SHALL be latched; the requester's inputs are ignored until ACK.
REQ-021 Entering ACCESS SHALL load the wait counter with WAIT_CYCLES-1; counter decrements each ACCESS cycle; ACCESS lasts exactly WAIT_CYCLES cycles.
REQ-022 During ACCESS: mem_bus_enable=1, mem_address/mem_wdata=latched values, mem_write_enable=latched we; outside ACCESS all mem_* outputs SHALL be 0.
REQ-023 On the last ACCESS cycle of a read, mem_rdata SHALL be registered into the owner's rdata; the other rdata and all rdata on writes SHALL hold.
REQ-024 In ACK the owner's ack SHALL be 1 for exactly one cycle; the other ack SHALL stay 0; acks are never both high.
REQ-025 Latency from req sampled in IDLE to ack SHALL be WAIT_CYCLES+1 cycles; minimum spacing between grants WAIT_CYCLES+2 cycles.
REQ-026 Requests asserted during ACCESS or ACK SHALL be evaluated only in the next IDLE cycle.
REQ-027 A requester dropping req mid-ACCESS SHALL not abort the access; ack is still issued.
REQ-028 A requester holding req in the IDLE cycle after its ack SHALL be treated as a new request.

Reset
REQ-029 reset low SHALL immediately force state IDLE, counter 0, all mem_* outputs 0, both ack 0, both rdata 8'h00, busy 0, last_grant=DMA (CPU wins first tie).
REQ-030 Reset asserted mid-ACCESS SHALL abandon the access with no ack and no rdata update; after release the first IDLE cycle re-arbitrates.

Verification
REQ-031 CPU read 16'h4005, mem_rdata=8'hA5, WAIT_CYCLES=1 -> mem_bus_enable high 1 cycle with mem_address 16'h4005, cpu_rdata=8'hA5 and cpu_ack pulse 2 cycles after req.
REQ-032 CPU and DMA request simultaneously from reset (CPU write 16'hC010=8'h3C, DMA read 16'h0020) -> CPU served first with mem_write_enable=1, then DMA; dma_rdata updated, cpu_rdata held.
REQ-033 Both requesters held continuously for 6 transactions -> grants alternate CPU, DMA, CPU, ..., never both acks high.
REQ-034 WAIT_CYCLES=3, DMA read -> ACCESS exactly 3 cycles, dma_ack 4 cycles after req, mem_rdata sampled on third ACCESS cycle only.
REQ-035 Reset pulled low on second cycle of a 3-cycle CPU read -> no cpu_ack, cpu_rdata=8'h00, mem_bus_enable low immediately; post-release pending DMA request granted first cycle.
REQ-036 CPU drops req after first ACCESS cycle -> access completes, cpu_ack still pulses once, next IDLE grants nothing.
